// File: rtl/alu_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial ALU.
// Combinational only, no latency or backpressure.
package alu_serial_pkg;

   typedef enum logic [1:0] {
      OP_NOR = 2'b00,
      OP_XOR = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } alu_state_e;

   // Width of a counter that has to reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_digit.sv
// alu_digit: DIGIT-wide chain of 1-bit NOR/XOR/ADD/SUB cells, carry rippling LSB to MSB.
// Purely combinational (zero latency); no handshake, so no backpressure.
module alu_digit
   import alu_serial_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   input  alu_op_e          op,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             c_msb_in
);

   logic w_c;
   logic w_be;

   always_comb begin
      w_c      = cin;
      w_be     = 1'b0;
      c_msb_in = cin;
      s_d      = '0;
      for (int i = 0; i < DIGIT; i++) begin
         // op[0] is 1 for SUB, turning the add into a + ~b + 1 via the carry-in
         w_be = b_d[i] ^ op[0];
         if (i == DIGIT - 1) begin
            c_msb_in = w_c;
         end
         case (op)
            OP_NOR:  s_d[i] = ~(a_d[i] | b_d[i]);
            OP_XOR:  s_d[i] = a_d[i] ^ b_d[i];
            default: s_d[i] = a_d[i] ^ w_be ^ w_c;
         endcase
         w_c = (a_d[i] & w_be) | (w_c & (a_d[i] ^ w_be));
      end
      cout = w_c;
   end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: WIDTH-bit NOR/XOR/ADD/SUB, DIGIT bits per clock LSB first; ALU_SERIAL_SAT_EN adds signed saturation.
// out_valid rises WIDTH/DIGIT cycles after accept; result held in DONE until out_ready, in_ready low while busy.
module alu_serial
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(NDIG);

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("alu_serial: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   alu_state_e             r_state;
   alu_state_e             w_state_nxt;
   alu_op_e                r_op;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_acc;
   logic [WIDTH-1:0]       r_result;
   logic [CW-1:0]          r_cnt;
   logic                   r_carry;
   logic                   r_cout;
   logic                   r_ovf;
   logic                   r_zero;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_arith;
   logic                   w_cout;
   logic                   w_cmsb;
   logic                   w_ovf_raw;
   logic [DIGIT-1:0]       w_s_d;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_acc_nxt;
   logic [WIDTH-1:0]       w_final;

   assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_cnt == CW'(NDIG - 1));
   assign w_arith   = r_op[1];
   assign w_ovf_raw = w_arith & (w_cmsb ^ w_cout);

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;
   assign zero   = r_zero;

   alu_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d      (r_a[DIGIT-1:0]),
      .b_d      (r_b[DIGIT-1:0]),
      .cin      (r_carry),
      .op       (r_op),
      .s_d      (w_s_d),
      .cout     (w_cout),
      .c_msb_in (w_cmsb)
   );

   // New digit enters at the MSB; after the last digit the accumulator is LSB-aligned.
   assign w_cat     = {w_s_d, r_acc};
   assign w_acc_nxt = WIDTH'(w_cat >> DIGIT);

   always_comb begin
      w_final = w_acc_nxt;
`ifdef ALU_SERIAL_SAT_EN
      // On the last digit r_a[DIGIT-1] is the captured sign bit of operand A.
      if (w_ovf_raw) begin
         w_final = r_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_op     <= OP_NOR;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_op    <= alu_op_e'(op);
         r_carry <= op[0];
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_acc   <= w_acc_nxt;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_arith & w_cout;
            r_ovf    <= w_ovf_raw;
            r_zero   <= ~|w_final;
         end
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances, queue scoreboard.
module tb_alu_serial;

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        sel;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic [1:0]  op_in;

   logic        iv8, rdy8, ov8, c8, v8, z8;
   logic [7:0]  r8;
   logic        iv16, rdy16, ov16, c16, v16, z16;
   logic [15:0] r16;

   logic        obs_rdy, obs_ov, obs_c, obs_v, obs_z;
   logic [15:0] obs_res;

   int   n_err = 0;
   int   n_chk = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   assign iv8     = in_valid && !sel;
   assign iv16    = in_valid && sel;
   assign obs_rdy = sel ? rdy16 : rdy8;
   assign obs_ov  = sel ? ov16  : ov8;
   assign obs_c   = sel ? c16   : c8;
   assign obs_v   = sel ? v16   : v8;
   assign obs_z   = sel ? z16   : z8;
   assign obs_res = sel ? r16   : {8'h00, r8};

   alu_serial #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
      .a(a_in[7:0]), .b(b_in[7:0]), .op(op_in),
      .out_valid(ov8), .out_ready(out_ready),
      .result(r8), .cout(c8), .ovf(v8), .zero(z8)
   );

   alu_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
      .a(a_in), .b(b_in), .op(op_in),
      .out_valid(ov16), .out_ready(out_ready),
      .result(r16), .cout(c16), .ovf(v16), .zero(z16)
   );

   // Reference: plain integer arithmetic on a w-bit word.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] op);
      exp_t        e;
      logic [16:0] mask;
      logic [16:0] be;
      logic [16:0] s;
      e    = '0;
      mask = (17'd1 << w) - 17'd1;
      case (op)
         2'b00: e.res = ~(a | b) & mask[15:0];
         2'b01: e.res = (a ^ b) & mask[15:0];
         default: begin
            be    = (op == 2'b11) ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
            s     = ({1'b0, a} & mask) + be + {16'd0, (op == 2'b11)};
            e.c   = s[w];
            e.v   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
            e.res = s[15:0] & mask[15:0];
`ifdef ALU_SERIAL_SAT_EN
            if (e.v) begin
               e.res = a[w-1] ? 16'(17'd1 << (w - 1)) : 16'(mask >> 1);
            end
`endif
         end
      endcase
      e.z = (e.res == 16'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      int n;
      n = 0;
      while (!obs_rdy && n < 50) begin
         step();
         n++;
      end
      chk("in_ready_wait", {31'd0, obs_rdy}, 32'd1);
      a_in     = a;
      b_in     = b;
      op_in    = op;
      in_valid = 1'b1;
      q.push_back(model(sel ? 16 : 8, a, b, op));
      step();
      in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int lat, input bit hs);
      int   cyc;
      exp_t e;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!obs_ov && cyc < 40);
      chk({tag, "_lat"}, cyc, lat);
      e = (q.size() > 0) ? q.pop_front() : '0;
      chk({tag, "_res"},  {16'd0, obs_res}, {16'd0, e.res});
      chk({tag, "_cout"}, {31'd0, obs_c}, {31'd0, e.c});
      chk({tag, "_ovf"},  {31'd0, obs_v}, {31'd0, e.v});
      chk({tag, "_zero"}, {31'd0, obs_z}, {31'd0, e.z});
      if (hs) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         chk({tag, "_vld_drop"}, {31'd0, obs_ov}, 32'd0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sel       = 1'b0;
      a_in      = '0;
      b_in      = '0;
      op_in     = 2'b00;
      step();
      step();
      chk("rst_vld8",   {31'd0, ov8},   32'd0);
      chk("rst_res8",   {24'd0, r8},    32'd0);
      chk("rst_rdy8",   {31'd0, rdy8},  32'd1);
      chk("rst_vld16",  {31'd0, ov16},  32'd0);
      chk("rst_rdy16",  {31'd0, rdy16}, 32'd1);
      rst_n = 1'b1;
      step();

      send(16'h7F, 16'h01, 2'b10); collect("add_7f_01", 8, 1);
      send(16'h00, 16'h01, 2'b11); collect("sub_00_01", 8, 1);
      send(16'h80, 16'h01, 2'b11); collect("sub_80_01", 8, 1);
      send(16'hF0, 16'h0F, 2'b00); collect("nor_f0_0f", 8, 1);
      send(16'hA5, 16'hA5, 2'b01); collect("xor_a5_a5", 8, 1);
      send(16'hC3, 16'h3D, 2'b10); collect("add_c3_3d", 8, 1);

      // Backpressure: hold DONE with stray in_valid, then handshake and accept together.
      send(16'h12, 16'h34, 2'b10); collect("bp_first", 8, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a_in     = 16'hAA;
         b_in     = 16'h55;
         op_in    = 2'b00;
         step();
         chk("bp_hold_res", {16'd0, obs_res}, 32'h46);
         chk("bp_hold_vld", {31'd0, obs_ov},  32'd1);
         chk("bp_hold_rdy", {31'd0, obs_rdy}, 32'd0);
      end
      a_in      = 16'h01;
      b_in      = 16'h02;
      op_in     = 2'b10;
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_with_ordy", {31'd0, obs_rdy}, 32'd1);
      q.push_back(model(8, 16'h01, 16'h02, 2'b10));
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("bp_nobubble_vld", {31'd0, obs_ov},  32'd0);
      chk("bp_nobubble_rdy", {31'd0, obs_rdy}, 32'd0);
      collect("bp_next", 8, 1);

      // Reset in the middle of RUN.
      send(16'h55, 16'h11, 2'b10);
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_vld", {31'd0, obs_ov},  32'd0);
      chk("midrst_res", {16'd0, obs_res}, 32'd0);
      chk("midrst_rdy", {31'd0, obs_rdy}, 32'd1);
      q.delete();
      step();
      step();
      rst_n = 1'b1;
      step();
      send(16'h10, 16'h20, 2'b10); collect("rst_add", 8, 1);

      sel = 1'b1;
      step();
      send(16'hFFFF, 16'h0001, 2'b10); collect("w16_add_ffff", 4, 1);
      send(16'h1234, 16'h1234, 2'b11); collect("w16_sub_eq", 4, 1);
      send(16'h7FFF, 16'h0001, 2'b10); collect("w16_add_ovf", 4, 1);
      send(16'h8000, 16'h0001, 2'b11); collect("w16_sub_ovf", 4, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
